// File: rtl/rv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rv_fetch_pkg
// Shared types and constants for the RV32I instruction-fetch front end.
//   fetch_state_e : fetch controller states (boot, running, flushing stale fetches)
//   ILEN          : instruction width in bits
//   INST_BYTES    : PC increment per sequential fetch
//   fetch_entry_t : {inst, pc} pair as seen by decode (for the default 32-bit PC)
//   cnt_width()   : width of a counter that must hold 0..depth inclusive
// -----------------------------------------------------------------------------
package rv_fetch_pkg;

    localparam int ILEN       = 32;
    localparam int INST_BYTES = 4;
    localparam int PC_W       = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

    // A counter bounded by 'depth' (inclusive) needs one bit more than the
    // index width of a depth-entry buffer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rv_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO for prefetched instructions, with single-cycle flush and an
// occupancy count. The head entry is read straight from the storage registers,
// so a push becomes visible at the head on the cycle after it is written.
//   clk, reset    : clock, synchronous active-high reset (pointers/count only)
//   flush_i       : empty the FIFO this cycle; overrides push and pop
//   push_i        : write push_data_i at the tail
//   pop_i         : discard the head entry (ignored when empty)
//   head_valid_o  : FIFO holds at least one entry
//   head_data_o   : head entry, forced to zero while empty
//   count_o       : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     head_valid_o,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; the slot being written is then the one just vacated.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; an empty FIFO masks whatever it holds.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/rv_fetch_unit.sv
// -----------------------------------------------------------------------------
// rv_fetch_unit
// RV32I instruction-fetch front end. Owns the PC, issues sequential word
// fetches to instruction memory, buffers responses in a prefetch FIFO and hands
// {inst, pc} pairs to decode. A redirect restarts fetch at a new PC and marks
// every fetch still in flight to be discarded when its response returns.
//   clk, reset                      : clock, synchronous active-high reset
//   redirect_valid / redirect_pc    : one-cycle restart request and target
//   imem_req_valid/ready/addr       : fetch request channel (word aligned)
//   imem_rsp_valid/data             : in-order fetch responses, always accepted
//   inst_valid/ready/data/pc        : decode-side instruction channel
// -----------------------------------------------------------------------------
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [ILEN-1:0]   imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ILEN-1:0]   inst_data,
    output logic [XLEN-1:0]   inst_pc
);

    localparam int              CNT_W    = cnt_width(FIFO_DEPTH);
    localparam int              ENTRY_W  = ILEN + XLEN;
    localparam logic [XLEN-1:0] BOOT_PC  = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(INST_BYTES);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;           // address of the next request
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;   // PC of the next response that will be kept
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             req_fire;
    logic             rsp_drop;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic [ENTRY_W-1:0] fifo_head;
    logic [XLEN-1:0]  redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit: a request is only issued if its response is guaranteed a FIFO
    // slot, counting both buffered entries and fetches still in flight.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && (state_q != S_BOOT) && !redirect_valid
                            && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response is stale if it belongs to a fetch issued before a redirect,
    // including one arriving in the redirect cycle itself.
    assign rsp_drop  = redirect_valid || (drop_q != '0);
    assign fifo_push = imem_rsp_valid && !rsp_drop;
    assign fifo_pop  = inst_valid && inst_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_valid),
        .push_i       (fifo_push),
        .push_data_i  ({imem_rsp_data, rsp_pc_q}),
        .pop_i        (fifo_pop),
        .head_valid_o (inst_valid),
        .head_data_o  (fifo_head),
        .count_o      (fifo_count)
    );

    assign inst_data = fifo_head[ENTRY_W-1:XLEN];
    assign inst_pc   = fifo_head[XLEN-1:0];

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    // On redirect every fetch still in flight after this cycle's response is
    // stale; no request fires in that cycle, so outstanding_d is exactly that.
    always_comb begin
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = outstanding_d;
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc_aligned;
        end else if (req_fire) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Responses return in request order and all stale ones are dropped, so
    // the next kept response always belongs to the PC tracked here.
    always_comb begin
        rsp_pc_d = rsp_pc_q;
        if (redirect_valid) begin
            rsp_pc_d = redirect_pc_aligned;
        end else if (fifo_push) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect_valid && (drop_d != '0)) state_d = S_FLUSH;
            S_FLUSH: if (drop_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_BOOT;
            pc_q          <= BOOT_PC;
            rsp_pc_q      <= BOOT_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_rv_fetch_unit.sv
module tb_rv_fetch_unit;
    import rv_fetch_pkg::*;

    localparam int          XLEN  = 32;
    localparam logic [31:0] RPC   = 32'h80;
    localparam int          DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [XLEN-1:0]   inst_pc;

    rv_fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat     = 1;
    int acc_cnt = 0;
    int cyc     = 0;

    fetch_entry_t exp_q[$];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } pend_t;

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        fetch_entry_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 32'(4 * i);
            e.inst = imem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    // imem model: fixed latency, in-order, one response per cycle.
    initial begin
        pend_t       pend[$];
        pend_t       p;
        logic        fire;
        logic        rs;
        logic [31:0] a;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            fire = imem_req_valid && imem_req_ready;
            a    = imem_req_addr;
            rs   = reset;
            @(posedge clk);
            #1;
            cyc++;
            if (rs) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (fire) begin
                    p.addr = a;
                    p.due  = 32'(cyc + lat - 1);
                    pend.push_back(p);
                    acc_cnt++;
                end
                if (pend.size() > 0 && int'(pend[0].due) <= cyc) begin
                    p = pend.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = imem_word(p.addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
            end
        end
    end

    // Scoreboard monitor: every accepted decode entry must match the queue head.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (!reset && inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %0h expected no entry", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", 64'(inst_pc), 64'(e.pc));
                    chk("inst_data", 64'(inst_data), 64'(e.inst));
                end
            end
        end
    end

    // Wait for k decode handshakes; span = cycles between first and last.
    task automatic drain(input int k, input bit stop, output int span);
        int got   = 0;
        int first = 0;
        int n     = 0;
        span = -1;
        while (got < k && n < 200) begin
            @(negedge clk);
            n++;
            if (!reset && inst_valid && inst_ready && !redirect_valid) begin
                if (got == 0) first = n;
                got++;
                if (got == k) span = n - first;
            end
        end
        if (got < k) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries expected %0d", got, k);
        end
        @(posedge clk);
        #1;
        if (stop) inst_ready = 1'b0;
    endtask

    // Two reset cycles; returns at the start of the first cycle after release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        acc_cnt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int span;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;

        // 1: reset values, first request on the second cycle after release
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t1_req_valid_rst", 64'(imem_req_valid), 64'd0);
        chk("t1_inst_valid_rst", 64'(inst_valid), 64'd0);
        chk("t1_req_addr_rst", 64'(imem_req_addr), 64'h80);
        chk("t1_inst_data_rst", 64'(inst_data), 64'd0);
        chk("t1_inst_pc_rst", 64'(inst_pc), 64'd0);
        @(negedge clk);
        chk("t1_req_valid_first", 64'(imem_req_valid), 64'd1);
        chk("t1_req_addr_first", 64'(imem_req_addr), 64'h80);

        // 2: streaming at latency 1, one instruction per cycle
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        expect_seq(32'h80, 8);
        drain(8, 1'b1, span);
        chk("t2_no_gaps", 64'(span), 64'd7);
        imem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        chk("t2_all_seen", 64'(exp_q.size()), 64'd0);

        // 3: decode stalled -> credit stops fetch at FIFO_DEPTH
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_accepted", 64'(acc_cnt), 64'd4);
        chk("t3_req_valid_low", 64'(imem_req_valid), 64'd0);
        chk("t3_inst_valid", 64'(inst_valid), 64'd1);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        expect_seq(32'h80, 4);
        drain(4, 1'b1, span);
        chk("t3_back_to_back", 64'(span), 64'd3);
        repeat (3) @(negedge clk);
        chk("t3_empty_after", 64'(inst_valid), 64'd0);

        // 4: redirect with two fetches in flight at latency 3
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        @(negedge clk);
        chk("t4_two_in_flight", 64'(acc_cnt), 64'd2);
        chk("t4_no_req_on_redirect", 64'(imem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        expect_seq(32'h200, 3);
        @(negedge clk);
        chk("t4_state_flush", 64'(dut.state_q), 64'(S_FLUSH));
        chk("t4_req_valid_new", 64'(imem_req_valid), 64'd1);
        chk("t4_req_addr_new", 64'(imem_req_addr), 64'h200);
        drain(3, 1'b1, span);
        chk("t4_state_run", 64'(dut.state_q), 64'(S_RUN));
        chk("t4_all_seen", 64'(exp_q.size()), 64'd0);

        // 5: redirect coinciding with a response and a decode handshake
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        expect_seq(32'h80, 4);
        drain(4, 1'b0, span);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        chk("t5_hs_in_redirect", 64'(inst_valid), 64'd1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_stale_valid", 64'(inst_valid), 64'd0);
        chk("t5_req_addr", 64'(imem_req_addr), 64'h300);
        expect_seq(32'h300, 2);
        drain(2, 1'b1, span);
        chk("t5_all_seen", 64'(exp_q.size()), 64'd0);

        // 6: reset in the middle of operation with three fetches in flight
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_pre_outstanding", 64'(dut.outstanding_q), 64'd3);
        chk("t6_pre_inst_valid", 64'(inst_valid), 64'd1);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        acc_cnt    = 0;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("t6_req_valid_rst", 64'(imem_req_valid), 64'd0);
        chk("t6_inst_valid_rst", 64'(inst_valid), 64'd0);
        chk("t6_req_addr_rst", 64'(imem_req_addr), 64'h80);
        chk("t6_inst_data_rst", 64'(inst_data), 64'd0);
        chk("t6_inst_pc_rst", 64'(inst_pc), 64'd0);
        expect_seq(32'h80, 3);
        drain(3, 1'b1, span);
        chk("t6_all_seen", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
